// File: rtl/pinmux_sel.sv
`default_nettype none
// ============================================================================
// Module   : pinmux_sel
// Purpose  : Per-pin peripheral selection multiplexer. Each output-capable pin
//            is driven by one of NUM_SRC peripheral sources, chosen through a
//            small register interface. Changing a selection first parks the pin
//            in a disabled "gap" for GAP_CYCLES cycles so that two sources are
//            never seen driving the pad back to back.
//
// Ports    : clk_i, rst_i             clock / synchronous active-high reset
//            bus_req_i, bus_we_i      single-cycle register request, 1 = write
//            bus_addr_i               pin index
//            bus_wdata_i              selection (0 = disabled, k = source k-1)
//            bus_rvalid_o             one-cycle response pulse per request
//            bus_rdata_o              read data (0 for writes / bad address)
//            bus_err_o                address out of range, with rvalid
//            periph_o_i, periph_oe_i  source s, pin p at bit s*NUM_PINS+p
//            pin_o, pin_oe_o          pad drive and output enable
//            pin_i                    asynchronous pad input
//            periph_i_o               synchronised pad input to the sources
//            switching_o              pin currently in its disabled gap
//
// Revision : 1.0 - initial release
// ============================================================================
module pinmux_sel #(
    parameter int   NUM_PINS   = 14,
    parameter int   NUM_SRC    = 4,
    parameter int   GAP_CYCLES = 2,
    parameter logic IN_DEFAULT = 1'b1,
    localparam int  SEL_W      = ($clog2(NUM_SRC + 1) > 1) ? $clog2(NUM_SRC + 1) : 1,
    localparam int  AW         = ($clog2(NUM_PINS) > 1) ? $clog2(NUM_PINS) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        bus_req_i,
    input  logic                        bus_we_i,
    input  logic [AW-1:0]               bus_addr_i,
    input  logic [SEL_W-1:0]            bus_wdata_i,
    output logic                        bus_rvalid_o,
    output logic [SEL_W-1:0]            bus_rdata_o,
    output logic                        bus_err_o,
    input  logic [NUM_SRC*NUM_PINS-1:0] periph_o_i,
    input  logic [NUM_SRC*NUM_PINS-1:0] periph_oe_i,
    output logic [NUM_PINS-1:0]         pin_o,
    output logic [NUM_PINS-1:0]         pin_oe_o,
    input  logic [NUM_PINS-1:0]         pin_i,
    output logic [NUM_SRC*NUM_PINS-1:0] periph_i_o,
    output logic [NUM_PINS-1:0]         switching_o
);

    // Per-pin state: ACTIVE drives the selected source, GAP holds the pin off.
    localparam logic [0:0] c_st_active = 1'b0;
    localparam logic [0:0] c_st_gap    = 1'b1;

    // Counter reload value; the cycle that sees zero is the last gap cycle.
    localparam logic [7:0] c_gap_load  = 8'(GAP_CYCLES - 1);

    logic [SEL_W-1:0]    r_act   [NUM_PINS];
    logic [SEL_W-1:0]    r_pend  [NUM_PINS];
    logic [7:0]          r_cnt   [NUM_PINS];
    logic [0:0]          r_state [NUM_PINS];

    logic [NUM_PINS-1:0] r_sync1;
    logic [NUM_PINS-1:0] r_sync2;

    logic                r_rvalid;
    logic [SEL_W-1:0]    r_rdata;
    logic                r_err;

    logic                w_addr_ok;
    logic [SEL_W-1:0]    w_wsel;
    logic                w_wr;
    logic                w_rd;
    logic [SEL_W-1:0]    w_rd_sel;

    assign w_addr_ok = (32'(bus_addr_i) < 32'(NUM_PINS));
    // Selections naming a non-existent source collapse to "disabled".
    assign w_wsel    = (32'(bus_wdata_i) > 32'(NUM_SRC)) ? '0 : bus_wdata_i;
    assign w_wr      = bus_req_i & bus_we_i & w_addr_ok;
    assign w_rd      = bus_req_i & ~bus_we_i & w_addr_ok;

    // Read-back shows the selection the pin is heading to while in the gap.
    always_comb begin
        w_rd_sel = '0;
        for (int p = 0; p < NUM_PINS; p++) begin
            if (bus_addr_i == AW'(p)) begin
                w_rd_sel = (r_state[p] == c_st_gap) ? r_pend[p] : r_act[p];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < NUM_PINS; p++) begin
                r_act[p]   <= '0;
                r_pend[p]  <= '0;
                r_cnt[p]   <= 8'd0;
                r_state[p] <= c_st_active;
            end
            r_sync1  <= {NUM_PINS{IN_DEFAULT}};
            r_sync2  <= {NUM_PINS{IN_DEFAULT}};
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_sync1  <= pin_i;
            r_sync2  <= r_sync1;
            r_rvalid <= bus_req_i;
            r_err    <= bus_req_i & ~w_addr_ok;
            r_rdata  <= w_rd ? w_rd_sel : '0;
            for (int p = 0; p < NUM_PINS; p++) begin
                if (w_wr && (bus_addr_i == AW'(p))) begin
                    // Rewriting the current selection of an active pin is a
                    // no-op; anything else (including any write mid-gap)
                    // (re)starts a full gap.
                    if (!((r_state[p] == c_st_active) && (w_wsel == r_act[p]))) begin
                        r_pend[p]  <= w_wsel;
                        r_cnt[p]   <= c_gap_load;
                        r_state[p] <= c_st_gap;
                    end
                end else if (r_state[p] == c_st_gap) begin
                    if (r_cnt[p] == 8'd0) begin
                        r_act[p]   <= r_pend[p];
                        r_state[p] <= c_st_active;
                    end else begin
                        r_cnt[p] <= r_cnt[p] - 8'd1;
                    end
                end
            end
        end
    end

    // Pad and peripheral-input routing; only the one selected source of an
    // active pin is connected, all other paths see safe defaults.
    always_comb begin
        pin_o       = '0;
        pin_oe_o    = '0;
        switching_o = '0;
        periph_i_o  = {(NUM_SRC*NUM_PINS){IN_DEFAULT}};
        for (int p = 0; p < NUM_PINS; p++) begin
            switching_o[p] = (r_state[p] == c_st_gap);
            for (int s = 0; s < NUM_SRC; s++) begin
                if ((r_state[p] == c_st_active) && (r_act[p] == SEL_W'(s + 1))) begin
                    pin_o[p]                    = periph_o_i[s*NUM_PINS + p];
                    pin_oe_o[p]                 = periph_oe_i[s*NUM_PINS + p];
                    periph_i_o[s*NUM_PINS + p]  = r_sync2[p];
                end
            end
        end
    end

    assign bus_rvalid_o = r_rvalid;
    assign bus_rdata_o  = r_rdata;
    assign bus_err_o    = r_err;

endmodule
`default_nettype wire

// File: doc/pinmux_sel.md
PINMUX_SEL -- requirements
Module: pinmux_sel

Interface
REQ-001 SHALL have parameter NUM_PINS, default 14, number of muxed output-capable pins.
REQ-002 SHALL have parameter NUM_SRC, default 4, peripheral sources selectable per pin.
REQ-003 SHALL have parameter GAP_CYCLES, default 2 (range 1..255), disabled-gap length on selection change.
REQ-004 SHALL have parameter IN_DEFAULT, default 1'b1, value presented to unselected peripheral inputs.
REQ-005 SHALL derive SEL_W = $clog2(NUM_SRC+1) and AW = $clog2(NUM_PINS), each minimum 1.
REQ-006 SHALL have one clock and a synchronous, active-high reset: clk_i input 1 (all state on rising edge) and rst_i input 1 (sampled only on clk_i edges).
REQ-007 bus_req_i  input  1  register access request, single cycle.
REQ-008 bus_we_i  input  1  1 = write, 0 = read.
REQ-009 bus_addr_i  input  AW  pin index.
REQ-010 bus_wdata_i  input  SEL_W  selection: 0 = disabled, k = source k-1.
REQ-011 bus_rvalid_o / bus_rdata_o / bus_err_o  output  1 / SEL_W / 1  response, rdata, address error.
REQ-012 periph_o_i / periph_oe_i  input  NUM_SRC*NUM_PINS each  source s, pin p at bit s*NUM_PINS+p.
REQ-013 pin_o / pin_oe_o  output  NUM_PINS each  pad drive and output enable.
REQ-014 pin_i  input  NUM_PINS  asynchronous pad input.
REQ-015 periph_i_o  output  NUM_SRC*NUM_PINS  synchronised pad input back to sources, same indexing.
REQ-016 switching_o  output  NUM_PINS  pin in gap state.

Function
REQ-017 SHALL keep per pin: active select act[p], pending select pend[p], gap counter cnt[p] (8 bit), state ACTIVE or GAP.
REQ-018 Write (req&we, addr<NUM_PINS): wdata==act and state ACTIVE -> no change; otherwise pend<=wdata, cnt<=GAP_CYCLES-1, state<=GAP next cycle.
REQ-019 Write during GAP SHALL overwrite pend and reload cnt to GAP_CYCLES-1 (gap restarts), even if wdata equals old act.
REQ-020 GAP: cnt decrements each cycle; on cycle with cnt==0, act<=pend, state<=ACTIVE; pin thus disabled exactly GAP_CYCLES cycles after the write edge.
REQ-021 wdata > NUM_SRC SHALL be stored as 0 (disabled).
REQ-022 Read (req&~we): one cycle later bus_rvalid_o=1, bus_rdata_o=pend if GAP else act; write also yields rvalid=1, rdata=0 next cycle.
REQ-023 addr>=NUM_PINS: write ignored, read rdata=0, bus_err_o=1 with the rvalid pulse; bus_err_o=0 otherwise.
REQ-024 bus_rvalid_o SHALL be a one-cycle pulse per request; back-to-back requests accepted every cycle.
REQ-025 ACTIVE with act=k>0: pin_o/pin_oe_o = periph_o_i/periph_oe_i of source k-1 combinationally; act=0 or GAP: pin_o=0, pin_oe_o=0.
REQ-026 pin_i SHALL pass a 2-flop synchroniser (reset value IN_DEFAULT); periph_i_o for source k-1 on pin p = synchronised pin_i[p] only when ACTIVE and act=k, else IN_DEFAULT.
REQ-027 switching_o[p] = 1 exactly while pin p is in GAP.

Reset
REQ-028 On rst_i: act=pend=0, cnt=0, state ACTIVE, sync flops=IN_DEFAULT, bus_rvalid_o=0, bus_rdata_o=0, bus_err_o=0; hence pin_o=0, pin_oe_o=0, switching_o=0, periph_i_o all IN_DEFAULT.
REQ-029 Reset asserted mid-gap or with a request in the same cycle SHALL win: request dropped, no rvalid afterwards.

Verification
REQ-030 Reset then write pin 3 = 2, GAP_CYCLES=2 -> switching_o[3]=1 for 2 cycles, then pin_o[3]/pin_oe_o[3] follow source 1 bit 1*14+3.
REQ-031 Pin 3 active=2, write 2 -> no gap, switching_o stays 0; read pin 3 -> rvalid next cycle, rdata=2, err=0.
REQ-032 Write pin 5 = 1, then one cycle later pin 5 = 3 -> gap restarts, total 3 disabled cycles, then source 2 drives; read during gap returns 3.
REQ-033 Write addr 14 (NUM_PINS=14) -> no pin change; read addr 15 -> rvalid=1, err=1, rdata=0; write wdata 7 (NUM_SRC=4) -> read returns 0.
REQ-034 Pin 0 act=1, toggle pin_i[0] -> periph_i_o bit 0 follows after 2 cycles; bits 14, 28, 42 stay 1.
REQ-035 Assert rst_i during gap -> next cycle all outputs at reset values, switching_o=0.
